// File: rtl/uart_rx_param_if.sv
// Receiver-side bundle: serial line, consumer handshake and received word/flags.
// master = the receiver, slave = the line driver / byte consumer.
`timescale 1ns/1ps
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx;
    logic                 ready_clr;
    logic                 ready;
    logic [DATA_BITS-1:0] data_out;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overrun;

    modport master (
        input  rx, ready_clr,
        output ready, data_out, frame_err, parity_err, overrun
    );

    modport slave (
        output rx, ready_clr,
        input  ready, data_out, frame_err, parity_err, overrun
    );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: configurable data width and stop-bit count,
// false-start rejection, framing-error and overrun flags.
// Optional parity check is built when UART_RX_PARITY_EN is defined;
// without it parity_err is tied low and PARITY_ODD has no effect.
`timescale 1ns/1ps
module uart_rx_param #(
    parameter int CLOCKS_PER_PULSE = 16,
    parameter int DATA_BITS        = 8,
    parameter int STOP_BITS        = 1,
    parameter int PARITY_ODD       = 0
) (
    input  logic clk,
    input  logic rstn,
    uart_rx_param_if.master bus
);
    localparam int CW = $clog2(CLOCKS_PER_PULSE);
    localparam int DW = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] HALF_LAST = CW'(CLOCKS_PER_PULSE / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLOCKS_PER_PULSE - 1);
    localparam logic [DW-1:0] DATA_LAST = DW'(DATA_BITS - 1);
    localparam logic [DW-1:0] STOP_LAST = DW'(STOP_BITS - 1);

    // Reject configurations the counters and framing cannot represent.
    if (CLOCKS_PER_PULSE < 4 || (CLOCKS_PER_PULSE % 2) != 0 ||
        DATA_BITS < 5 || DATA_BITS > 9 ||
        STOP_BITS < 1 || STOP_BITS > 2 ||
        PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
        $error("uart_rx_param: unsupported parameter combination");
    end

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    localparam logic PODD = (PARITY_ODD != 0);
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t               state;
    logic                 rx_q1, rx_s;
    logic [CW-1:0]        bit_cnt;
    logic [DW-1:0]        data_cnt;   // data bit index, reused as stop bit index
    logic [DATA_BITS-1:0] shreg;
    logic                 fe_acc;     // low stop sample seen before the last one
    logic                 ready_q, ferr_q, ovr_q;
    logic [DATA_BITS-1:0] data_q;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit, perr_q;
`endif

    assign bus.ready     = ready_q;
    assign bus.data_out  = data_q;
    assign bus.frame_err = ferr_q;
    assign bus.overrun   = ovr_q;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = perr_q;
`else
    assign bus.parity_err = 1'b0;
`endif

    // Two-flop synchroniser; resets to idle-high so a reset never looks like a start edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_q1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            rx_q1 <= bus.rx;
            rx_s  <= rx_q1;
        end
    end

    // Frame FSM with registered outputs; a commit in the same cycle as ready_clr wins.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            data_cnt <= '0;
            shreg    <= '0;
            fe_acc   <= 1'b0;
            ready_q  <= 1'b0;
            data_q   <= '0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit  <= 1'b0;
            perr_q   <= 1'b0;
`endif
        end else begin
            if (bus.ready_clr) begin
                ready_q <= 1'b0;
                ovr_q   <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        bit_cnt <= '0;
                        state   <= START;
                    end
                end
                START: begin
                    if (bit_cnt == HALF_LAST) begin
                        bit_cnt <= '0;
                        if (rx_s) begin
                            state <= IDLE;       // line went back high: glitch, not a start bit
                        end else begin
                            state    <= DATA;
                            data_cnt <= '0;
                            fe_acc   <= 1'b0;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        // LSB first: after DATA_BITS shifts the first bit sits at bit 0.
                        shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                        if (data_cnt == DATA_LAST) begin
                            data_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                            state    <= PARITY;
`else
                            state    <= STOP;
`endif
                        end else begin
                            data_cnt <= data_cnt + 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt  <= '0;
                        par_bit  <= rx_s;
                        data_cnt <= '0;
                        state    <= STOP;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        if (data_cnt == STOP_LAST) begin
                            // Commit even on a framing error; leave half a bit early to resync.
                            data_q   <= shreg;
                            ready_q  <= 1'b1;
                            ferr_q   <= fe_acc | ~rx_s;
`ifdef UART_RX_PARITY_EN
                            perr_q   <= (^shreg) ^ PODD ^ par_bit;
`endif
                            if (ready_q && !bus.ready_clr) ovr_q <= 1'b1;
                            data_cnt <= '0;
                            state    <= IDLE;
                        end else begin
                            fe_acc   <= fe_acc | ~rx_s;
                            data_cnt <= data_cnt + 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: an 8N1 instance at defaults and a
// 7-data/2-stop instance; parity stimulus follows UART_RX_PARITY_EN.
`timescale 1ns/1ps
module tb_uart_rx_param;
    localparam int CPP = 16;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int LAT8 = 2 + CPP / 2 + (8 + int'(PAR) + 1) * CPP + 1;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    uart_rx_param_if #(.DATA_BITS(8)) if8 ();
    uart_rx_param_if #(.DATA_BITS(7)) if7 ();

    uart_rx_param #(.CLOCKS_PER_PULSE(CPP)) u_dut8 (
        .clk (clk), .rstn(rstn), .bus(if8)
    );

    uart_rx_param #(.CLOCKS_PER_PULSE(CPP), .DATA_BITS(7), .STOP_BITS(2), .PARITY_ODD(0)) u_dut7 (
        .clk (clk), .rstn(rstn), .bus(if7)
    );

    int n_run  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic bit_out(input bit sel, input logic v);
        if (sel) if7.rx = v; else if8.rx = v;
        repeat (CPP) @(negedge clk);
    endtask

    // Start, nb data bits LSB first, parity bit when built in, ns stop bits (stops[0] first).
    task automatic send(input bit sel, input logic [8:0] d, input int nb, input logic pbit,
                        input logic [1:0] stops, input int ns);
        bit_out(sel, 1'b0);
        for (int i = 0; i < nb; i++) bit_out(sel, d[i]);
        if (PAR) bit_out(sel, pbit);
        for (int i = 0; i < ns; i++) bit_out(sel, stops[i]);
        if (sel) if7.rx = 1'b1; else if8.rx = 1'b1;
    endtask

    task automatic clr(input bit sel);
        if (sel) if7.ready_clr = 1'b1; else if8.ready_clr = 1'b1;
        @(negedge clk);
        if (sel) if7.ready_clr = 1'b0; else if8.ready_clr = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        if8.rx = 1'b1; if8.ready_clr = 1'b0;
        if7.rx = 1'b1; if7.ready_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready",   32'(if8.ready),      32'h0);
        chk("rst_data",    32'(if8.data_out),   32'h0);
        chk("rst_ferr",    32'(if8.frame_err),  32'h0);
        chk("rst_perr",    32'(if8.parity_err), 32'h0);
        chk("rst_ovr",     32'(if8.overrun),    32'h0);
        rstn = 1'b1;
        repeat (3) @(negedge clk);

        // 1: 0x55, latency, sticky ready, clear
        fork
            send(0, 9'h055, 8, ^8'h55, 2'b11, 1);
            begin
                lat = 0;
                while (!if8.ready && lat < 400) begin @(negedge clk); lat++; end
            end
        join
        chk("t1_latency_win", 32'(lat >= LAT8 - 1 && lat <= LAT8 + 1), 32'h1);
        chk("t1_ready", 32'(if8.ready),     32'h1);
        chk("t1_data",  32'(if8.data_out),  32'h55);
        chk("t1_ferr",  32'(if8.frame_err), 32'h0);
        repeat (100) @(negedge clk);
        chk("t1_ready_hold", 32'(if8.ready), 32'h1);
        clr(0);
        chk("t1_ready_clr", 32'(if8.ready), 32'h0);

        // 2: 4-clk glitch rejected, then 0xC3
        if8.rx = 1'b0;
        repeat (4) @(negedge clk);
        if8.rx = 1'b1;
        repeat (40) @(negedge clk);
        chk("t2_glitch_ready", 32'(if8.ready), 32'h0);
        send(0, 9'h0C3, 8, ^8'hC3, 2'b11, 1);
        chk("t2_ready", 32'(if8.ready),     32'h1);
        chk("t2_data",  32'(if8.data_out),  32'hC3);
        chk("t2_ferr",  32'(if8.frame_err), 32'h0);
        clr(0);

        // 3: low stop bit -> framing error, then clean frame clears it
        send(0, 9'h0A3, 8, ^8'hA3, 2'b00, 1);
        repeat (CPP) @(negedge clk);
        chk("t3_ready", 32'(if8.ready),     32'h1);
        chk("t3_data",  32'(if8.data_out),  32'hA3);
        chk("t3_ferr",  32'(if8.frame_err), 32'h1);
        clr(0);
        send(0, 9'h00F, 8, ^8'h0F, 2'b11, 1);
        chk("t3_data2", 32'(if8.data_out),  32'h0F);
        chk("t3_ferr2", 32'(if8.frame_err), 32'h0);
        clr(0);

        // 4: overrun, clear, and ready_clr on the commit cycle
        send(0, 9'h011, 8, ^8'h11, 2'b11, 1);
        send(0, 9'h022, 8, ^8'h22, 2'b11, 1);
        chk("t4_data",  32'(if8.data_out), 32'h22);
        chk("t4_ovr",   32'(if8.overrun),  32'h1);
        chk("t4_ready", 32'(if8.ready),    32'h1);
        clr(0);
        chk("t4_clr_ready", 32'(if8.ready),   32'h0);
        chk("t4_clr_ovr",   32'(if8.overrun), 32'h0);
        send(0, 9'h044, 8, ^8'h44, 2'b11, 1);
        chk("t4_ready_pre", 32'(if8.ready), 32'h1);
        fork
            send(0, 9'h033, 8, ^8'h33, 2'b11, 1);
            begin
                repeat (LAT8 - 1) @(negedge clk);
                if8.ready_clr = 1'b1;
                @(negedge clk);
                if8.ready_clr = 1'b0;
            end
        join
        chk("t4_cc_ready", 32'(if8.ready),    32'h1);
        chk("t4_cc_ovr",   32'(if8.overrun),  32'h0);
        chk("t4_cc_data",  32'(if8.data_out), 32'h33);

        // 5: 7 data bits, 2 stop bits, parity when built in
        send(1, 9'h007, 7, 1'b0, 2'b11, 2);
        chk("t5_perr_bad", 32'(if7.parity_err), PAR ? 32'h1 : 32'h0);
        chk("t5_data_a",   32'(if7.data_out),   32'h07);
        chk("t5_ferr_a",   32'(if7.frame_err),  32'h0);
        clr(1);
        send(1, 9'h007, 7, 1'b1, 2'b11, 2);
        chk("t5_perr_ok", 32'(if7.parity_err), 32'h0);
        chk("t5_data_b",  32'(if7.data_out),   32'h07);
        clr(1);
        send(1, 9'h005, 7, ^7'h05, 2'b01, 2);
        repeat (CPP) @(negedge clk);
        chk("t5_ferr_stop2", 32'(if7.frame_err), 32'h1);
        chk("t5_data_c",     32'(if7.data_out),  32'h05);
        clr(1);

        // 6: reset mid-frame, then a clean frame
        chk("t6_pre_ready", 32'(if8.ready), 32'h1);
        fork
            send(0, 9'h09C, 8, ^8'h9C, 2'b11, 1);
            begin
                repeat (60) @(negedge clk);
                rstn = 1'b0;
                #1;
                chk("t6_rst_ready", 32'(if8.ready),      32'h0);
                chk("t6_rst_data",  32'(if8.data_out),   32'h0);
                chk("t6_rst_ferr",  32'(if8.frame_err),  32'h0);
                chk("t6_rst_perr",  32'(if8.parity_err), 32'h0);
                chk("t6_rst_ovr",   32'(if8.overrun),    32'h0);
            end
        join
        rstn = 1'b1;
        repeat (CPP) @(negedge clk);
        send(0, 9'h03A, 8, ^8'h3A, 2'b11, 1);
        chk("t6_data",  32'(if8.data_out),   32'h3A);
        chk("t6_ready", 32'(if8.ready),      32'h1);
        chk("t6_ferr",  32'(if8.frame_err),  32'h0);
        chk("t6_perr",  32'(if8.parity_err), 32'h0);
        chk("t6_ovr",   32'(if8.overrun),    32'h0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver. Successor to the fixed 8N1 receiver. Adds:
- configurable data width and stop-bit count
- false-start rejection
- framing-error and overrun flags
- optional parity checking
Sits between the board RX pin and the byte-consumer logic. Holds each received word until the consumer acknowledges it with ready_clr.

Parameters:
CLOCKS_PER_PULSE, 16, clk cycles per bit period; even, >= 4.
DATA_BITS, 8, data bits per frame; 5..9.
STOP_BITS, 1, stop bits checked per frame; 1 or 2.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; used only with UART_RX_PARITY_EN.

Ports:
clk  input  1  system clock.
rstn  input  1  asynchronous active-low reset.
rx  input  1  asynchronous serial line; idle high.
ready_clr  input  1  consumer acknowledge; clears ready and overrun.
ready  output  1  received word valid; sticky until ready_clr.
data_out  output  DATA_BITS  last received word, LSB = first data bit.
frame_err  output  1  last word had a low stop-bit sample.
parity_err  output  1  last word failed parity check.
overrun  output  1  a word was committed while ready was already 1; sticky.

Behaviour:
- Reset and clocking: rstn asynchronous, active-low; clock clk. All state updates on posedge clk.
- Reset values: ready=0, data_out=0, frame_err=0, parity_err=0, overrun=0, state=IDLE, counters=0. The 2-flop rx synchroniser resets to 1.
- rx_s is the second synchroniser flop; every decision uses rx_s only.
- Bit counter is $clog2(CLOCKS_PER_PULSE) bits wide and never compares beyond CLOCKS_PER_PULSE-1.
- Data counter is $clog2(DATA_BITS+1) bits wide.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: when rx_s==0, clear the bit counter and go to START.
- START: count to CLOCKS_PER_PULSE/2-1 (mid start bit). There, if rx_s==1, treat as a false start: return to IDLE with no flag change. Otherwise clear the counter and go to DATA.
- DATA: sample rx_s when counter==CLOCKS_PER_PULSE-1 into shift position data_cnt, LSB first. After DATA_BITS samples go to PARITY if UART_RX_PARITY_EN is defined, else to STOP.
- PARITY: one bit period; sample the parity bit at the counter terminal count, then go to STOP.
- STOP: STOP_BITS bit periods. Any stop sample == 0 marks a framing error. At the last stop sample:
  - data_out <= shift register; ready <= 1;
  - frame_err and parity_err are loaded for this word;
  - go to IDLE at once (half a bit early, for resync).
- Latency: ready rises (2 sync + CLOCKS_PER_PULSE/2 + (DATA_BITS + P + STOP_BITS) x CLOCKS_PER_PULSE + 1) clk after rx falls, where P = 1 with parity, else 0. Tolerance is +/-1 clk.
- A framing error does not suppress the commit: data_out is still updated.
- If rx stays low after the stop bit (break), IDLE restarts a frame. This is allowed; each such frame reports frame_err=1.
- Overrun: commit while ready==1 and no ready_clr in the same cycle sets overrun=1. data_out is overwritten with the newest word.
- ready_clr: clears ready and overrun next clk. frame_err and parity_err hold until the next commit.
- ready_clr and commit in the same cycle: commit wins. ready stays 1 and overrun is not set.
- ready_clr while ready==0: no effect.
- rstn asserted mid-frame: abort immediately to reset values. The receiver must wait for a new high-to-low edge before starting again.

Optional Feature:
UART_RX_PARITY_EN
- Defined: the PARITY state is present. Expected parity bit = XOR of data bits XOR PARITY_ODD. parity_err=1 on mismatch. Frame length grows by one bit.
- Undefined: the PARITY state and logic are absent. parity_err is tied to 0 and PARITY_ODD is ignored.

Test Plan:
1. Defaults, no macro; send 0x55 8N1 -> ready=1, data_out=0x55, frame_err=0. ready stays 1 for 100 clk until a ready_clr pulse, then 0 next clk.
2. rx low for 4 clk then high (glitch) -> state returns to IDLE, ready=0. A following 0xC3 frame is received correctly.
3. Send 0xA3 with stop bit driven 0 -> ready=1, data_out=0xA3, frame_err=1. Next clean 0x0F -> frame_err=0.
4. Send 0x11 then 0x22 with no ready_clr -> data_out=0x22, overrun=1. Pulse ready_clr -> ready=0, overrun=0. Pulse ready_clr on the commit cycle of a third byte -> ready=1, overrun=0.
5. UART_RX_PARITY_EN, PARITY_ODD=0, DATA_BITS=7, STOP_BITS=2:
   - 0x07 with parity bit 0 -> parity_err=1.
   - 0x07 with parity bit 1 -> parity_err=0, data_out=7'h07.
6. Assert rstn mid-DATA of 0x9C -> all outputs 0 at once. Release, then send 0x3A -> data_out=0x3A, ready=1, no flags.
